// File: rtl/player_pkg.sv
// Shared encodings for the key-to-command path: decoder command codes,
// UI mode and the two controller state machines.
package player_pkg;
  localparam logic [1:0] CMD_VOL = 2'b01;
  localparam logic [1:0] CMD_TRK = 2'b10;
  localparam logic [1:0] CMD_PAU = 2'b11;

  typedef enum logic {MODE_TRACK = 1'b0, MODE_VOLUME = 1'b1} mode_e;
  typedef enum logic {IDLE = 1'b0, WAIT2 = 1'b1} dbl_state_e;
  typedef enum logic {H_IDLE = 1'b0, H_REQ = 1'b1} iss_state_e;
endpackage

// File: rtl/key_cmd_ctrl_dbl_press_det.sv
// Splits mode-key strobes into single presses (window expired) and
// double presses (second strobe inside the window).
module dbl_press_det
  import player_pkg::*;
#(
  parameter logic [23:0] DBL_WIN = 24'd2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic single_p,
  output logic double_p
);
  localparam logic [23:0] LAST = DBL_WIN - 24'd1;

  dbl_state_e  state;
  logic [23:0] cnt;

  // Decoded from the held state so the owner of paused/mode can react in the
  // same cycle as the top-level track/volume keys.
  assign double_p = (state == WAIT2) && key && (cnt < LAST);
  assign single_p = (state == WAIT2) && !double_p && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (key) begin
          state <= WAIT2;
          cnt   <= '0;
        end
        WAIT2: begin
          if (double_p || single_p) state <= IDLE;
          else                      cnt   <= cnt + 24'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/key_cmd_ctrl.sv
// Turns debounced key strobes into track/volume/pause commands and issues
// them one at a time to the decoder command writer over req/ack.
module key_cmd_ctrl
  import player_pkg::*;
#(
  parameter int          NUM_TRACKS = 8,
  parameter int          TRK_W      = 3,
  parameter logic [7:0]  VOL_STEP   = 8'h08,
  parameter logic [7:0]  VOL_MAX    = 8'hF8,
  parameter logic [7:0]  VOL_RST    = 8'h20,
  parameter logic [23:0] DBL_WIN    = 24'd2_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       key_p,
  output logic             vs_req,
  output logic [1:0]       vs_cmd,
  output logic [7:0]       vs_arg,
  input  logic             vs_ack,
  output logic             mode_o,
  output logic             paused_o,
  output logic [TRK_W-1:0] track_o
);
  localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(NUM_TRACKS - 1);

  mode_e           mode;
  iss_state_e      ist;
  logic [7:0]      vol, vol_nxt;
  logic [TRK_W-1:0] trk_nxt;
  logic            paused;
  logic            pend_trk, pend_pau, pend_vol;
  logic            single_p, double_p;
  logic            nk, pk, trk_evt, vol_evt;
  logic            sel_trk, sel_pau, sel_vol;

  dbl_press_det #(.DBL_WIN(DBL_WIN)) u_dbl (
    .clk      (clk),
    .rst      (rst),
    .key      (key_p[2]),
    .single_p (single_p),
    .double_p (double_p)
  );

  // Mode key masks the others; simultaneous up+down cancels out.
  assign nk = key_p[1] & ~key_p[0] & ~key_p[2];
  assign pk = key_p[0] & ~key_p[1] & ~key_p[2];

  always_comb begin
    trk_nxt = track_o;
    vol_nxt = vol;
    if (mode == MODE_TRACK) begin
      if (nk)      trk_nxt = (track_o == TRK_LAST) ? '0 : track_o + 1'b1;
      else if (pk) trk_nxt = (track_o == '0) ? TRK_LAST : track_o - 1'b1;
    end else begin
      if (nk)      vol_nxt = (vol < VOL_STEP) ? 8'h00 : vol - VOL_STEP;
      else if (pk) vol_nxt = (vol > VOL_MAX - VOL_STEP) ? VOL_MAX : vol + VOL_STEP;
    end
  end

  assign trk_evt = (mode == MODE_TRACK) && (nk || pk);
  assign vol_evt = (vol_nxt != vol);

  assign sel_trk = (ist == H_IDLE) && pend_trk;
  assign sel_pau = (ist == H_IDLE) && !pend_trk && pend_pau;
  assign sel_vol = (ist == H_IDLE) && !pend_trk && !pend_pau && pend_vol;

  assign mode_o   = mode;
  assign paused_o = paused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode    <= MODE_TRACK;
      paused  <= 1'b0;
      track_o <= '0;
      vol     <= VOL_RST;
    end else begin
      track_o <= trk_nxt;
      vol     <= vol_nxt;
      if (single_p) mode   <= (mode == MODE_TRACK) ? MODE_VOLUME : MODE_TRACK;
      if (double_p) paused <= ~paused;
    end
  end

  // A new event in the same cycle as its pick wins: the latched value is
  // already stale, so the type must be resent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ist      <= H_IDLE;
      vs_req   <= 1'b0;
      vs_cmd   <= 2'b00;
      vs_arg   <= 8'h00;
      pend_trk <= 1'b0;
      pend_pau <= 1'b0;
      pend_vol <= 1'b1;
    end else begin
      pend_trk <= (pend_trk & ~sel_trk) | trk_evt;
      pend_pau <= (pend_pau & ~sel_pau) | double_p;
      pend_vol <= (pend_vol & ~sel_vol) | vol_evt;
      case (ist)
        H_IDLE: begin
          if (sel_trk) begin
            vs_cmd <= CMD_TRK;
            vs_arg <= 8'(track_o);
          end else if (sel_pau) begin
            vs_cmd <= CMD_PAU;
            vs_arg <= {7'b0, paused};
          end else if (sel_vol) begin
            vs_cmd <= CMD_VOL;
            vs_arg <= vol;
          end
          if (sel_trk || sel_pau || sel_vol) begin
            vs_req <= 1'b1;
            ist    <= H_REQ;
          end
        end
        H_REQ: if (vs_ack) begin
          vs_req <= 1'b0;
          ist    <= H_IDLE;
        end
        default: ist <= H_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed bench for key_cmd_ctrl with a short double-press window.
module tb_key_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_p;
  logic       vs_req, vs_ack;
  logic [1:0] vs_cmd;
  logic [7:0] vs_arg;
  logic       mode_o, paused_o;
  logic [2:0] track_o;

  int n_chk = 0;
  int n_fail = 0;
  logic       ack_en;
  int         ack_cnt;
  logic       req_seen;
  logic [9:0] log_q[$];

  key_cmd_ctrl #(.DBL_WIN(24'd200)) dut (
    .clk(clk), .rst(rst), .key_p(key_p), .vs_req(vs_req), .vs_cmd(vs_cmd),
    .vs_arg(vs_arg), .vs_ack(vs_ack), .mode_o(mode_o), .paused_o(paused_o),
    .track_o(track_o)
  );

  always #5 clk = ~clk;

  // Decoder-side model: record each request on its rising edge, ack after 3 cycles.
  always @(negedge clk) begin
    if (vs_req && !req_seen) log_q.push_back({vs_cmd, vs_arg});
    req_seen = vs_req;
    if (!ack_en || !vs_req) begin
      vs_ack  = 1'b0;
      ack_cnt = 0;
    end else if (!vs_ack) begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        vs_ack  = 1'b1;
        ack_cnt = 0;
      end
    end
  end

  task automatic pulse(input logic [2:0] k);
    @(negedge clk); key_p = k;
    @(negedge clk); key_p = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; key_p = 3'b000; ack_en = 1'b1; vs_ack = 1'b0; req_seen = 1'b0;
    #1;
    n_chk++; if (vs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", vs_req); end
    n_chk++; if (vs_cmd !== 2'b00) begin n_fail++; $display("FAIL reset_cmd got %b want 00", vs_cmd); end
    n_chk++; if (vs_arg !== 8'h00) begin n_fail++; $display("FAIL reset_arg got %h want 00", vs_arg); end
    n_chk++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL reset_mode got %b want 0", mode_o); end
    n_chk++; if (paused_o !== 1'b0) begin n_fail++; $display("FAIL reset_paused got %b want 0", paused_o); end
    n_chk++; if (track_o !== 3'd0) begin n_fail++; $display("FAIL reset_track got %0d want 0", track_o); end
    idle(3);
    rst = 1'b1;
    idle(30);
    n_chk++; if (log_q.size() !== 1) begin n_fail++; $display("FAIL init_vol_count got %0d want 1", log_q.size()); end
    else begin
      n_chk++; if (log_q[0] !== {2'b01, 8'h20}) begin n_fail++; $display("FAIL init_vol_req got %h want %h", log_q[0], {2'b01, 8'h20}); end
    end
    n_chk++; if (vs_req !== 1'b0) begin n_fail++; $display("FAIL init_req_idle got %b want 0", vs_req); end
  endtask

  task automatic test_track;
    log_q.delete();
    pulse(3'b001);
    n_chk++; if (track_o !== 3'd7) begin n_fail++; $display("FAIL prev_wrap got %0d want 7", track_o); end
    n_chk++; if (vs_req !== 1'b0) begin n_fail++; $display("FAIL latency_early got %b want 0", vs_req); end
    @(negedge clk);
    n_chk++; if (vs_req !== 1'b1) begin n_fail++; $display("FAIL latency_n2 got %b want 1", vs_req); end
    idle(12);
    pulse(3'b010);
    n_chk++; if (track_o !== 3'd0) begin n_fail++; $display("FAIL next_wrap got %0d want 0", track_o); end
    idle(12);
    pulse(3'b001);
    idle(12);
    pulse(3'b011);
    idle(12);
    n_chk++; if (track_o !== 3'd7) begin n_fail++; $display("FAIL both_keys_ignored got %0d want 7", track_o); end
    n_chk++; if (log_q.size() !== 3) begin n_fail++; $display("FAIL track_count got %0d want 3", log_q.size()); end
    else begin
      n_chk++; if (log_q[0] !== {2'b10, 8'h07}) begin n_fail++; $display("FAIL track_req0 got %h want %h", log_q[0], {2'b10, 8'h07}); end
      n_chk++; if (log_q[1] !== {2'b10, 8'h00}) begin n_fail++; $display("FAIL track_req1 got %h want %h", log_q[1], {2'b10, 8'h00}); end
      n_chk++; if (log_q[2] !== {2'b10, 8'h07}) begin n_fail++; $display("FAIL track_req2 got %h want %h", log_q[2], {2'b10, 8'h07}); end
    end
  endtask

  task automatic test_mode_volume;
    log_q.delete();
    pulse(3'b100);
    idle(100);
    n_chk++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL mode_early got %b want 0", mode_o); end
    idle(150);
    n_chk++; if (mode_o !== 1'b1) begin n_fail++; $display("FAIL mode_toggle got %b want 1", mode_o); end
    n_chk++; if (log_q.size() !== 0) begin n_fail++; $display("FAIL mode_no_req got %0d want 0", log_q.size()); end
    for (int i = 0; i < 30; i++) begin
      pulse(3'b001);
      idle(10);
    end
    n_chk++; if (track_o !== 3'd7) begin n_fail++; $display("FAIL vol_mode_track got %0d want 7", track_o); end
    n_chk++; if (log_q.size() !== 27) begin n_fail++; $display("FAIL vol_sat_count got %0d want 27", log_q.size()); end
    else begin
      n_chk++; if (log_q[26] !== {2'b01, 8'hF8}) begin n_fail++; $display("FAIL vol_sat_last got %h want %h", log_q[26], {2'b01, 8'hF8}); end
      n_chk++; if (log_q[0] !== {2'b01, 8'h28}) begin n_fail++; $display("FAIL vol_first got %h want %h", log_q[0], {2'b01, 8'h28}); end
    end
  endtask

  task automatic test_pause;
    log_q.delete();
    pulse(3'b100);
    idle(98);
    pulse(3'b100);
    n_chk++; if (paused_o !== 1'b1) begin n_fail++; $display("FAIL paused got %b want 1", paused_o); end
    idle(250);
    n_chk++; if (mode_o !== 1'b1) begin n_fail++; $display("FAIL pause_mode_kept got %b want 1", mode_o); end
    n_chk++; if (log_q.size() !== 1) begin n_fail++; $display("FAIL pause_count got %0d want 1", log_q.size()); end
    else begin
      n_chk++; if (log_q[0] !== {2'b11, 8'h01}) begin n_fail++; $display("FAIL pause_req got %h want %h", log_q[0], {2'b11, 8'h01}); end
    end
  endtask

  task automatic test_back_to_back;
    pulse(3'b100);
    idle(250);
    n_chk++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL b2b_track_mode got %b want 0", mode_o); end
    log_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin pulse(3'b010); idle(4); end
    pulse(3'b100);
    idle(250);
    for (int i = 0; i < 2; i++) begin pulse(3'b010); idle(4); end
    n_chk++; if (vs_req !== 1'b1) begin n_fail++; $display("FAIL b2b_held got %b want 1", vs_req); end
    ack_en = 1'b1;
    idle(40);
    n_chk++; if (log_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", log_q.size()); end
    else begin
      n_chk++; if (log_q[0] !== {2'b10, 8'h00}) begin n_fail++; $display("FAIL b2b_inflight got %h want %h", log_q[0], {2'b10, 8'h00}); end
      n_chk++; if (log_q[1] !== {2'b10, 8'h02}) begin n_fail++; $display("FAIL b2b_track got %h want %h", log_q[1], {2'b10, 8'h02}); end
      n_chk++; if (log_q[2] !== {2'b01, 8'hE8}) begin n_fail++; $display("FAIL b2b_vol got %h want %h", log_q[2], {2'b01, 8'hE8}); end
    end
  endtask

  task automatic test_reset_mid;
    ack_en = 1'b0;
    pulse(3'b010);
    for (int i = 0; i < 20 && !vs_req; i++) @(negedge clk);
    n_chk++; if (vs_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_up got %b want 1", vs_req); end
    rst = 1'b0;
    #1;
    n_chk++; if (vs_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop got %b want 0", vs_req); end
    n_chk++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL mid_mode got %b want 0", mode_o); end
    n_chk++; if (paused_o !== 1'b0) begin n_fail++; $display("FAIL mid_paused got %b want 0", paused_o); end
    n_chk++; if (track_o !== 3'd0) begin n_fail++; $display("FAIL mid_track got %0d want 0", track_o); end
    idle(3);
    log_q.delete();
    ack_en = 1'b1;
    rst = 1'b1;
    idle(30);
    n_chk++; if (log_q.size() !== 1) begin n_fail++; $display("FAIL mid_rel_count got %0d want 1", log_q.size()); end
    else begin
      n_chk++; if (log_q[0] !== {2'b01, 8'h20}) begin n_fail++; $display("FAIL mid_rel_vol got %h want %h", log_q[0], {2'b01, 8'h20}); end
    end
  endtask

  initial begin
    test_reset();
    test_track();
    test_mode_volume();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
